uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single `sender` UART transmitter among up to `N_REQ` byte producers. It grants one requester at a time, latches that requester's byte onto the sender's `message` input and issues a one-cycle active-low `start` pulse. The sender has no busy output, so the arbiter counts out the frame itself and blocks further grants until the frame has finished. It sits between the producer logic and `sender`, on the same `CLK`.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8. Derived localparam `IDW` = clog2(`N_REQ`), which is 2 at the default.
- `CLKS_PER_BIT`, default 5: `CLK` cycles per UART bit, matching the sender's bit period.
- `FRAME_BITS`, default 10: start bit + 8 data bits + stop bit.
- `GAP_CLKS`, default 0: extra idle cycles appended after each frame.
- Derived `FRAME_CLKS` = `CLKS_PER_BIT`*`FRAME_BITS`+`GAP_CLKS`. Legal range is 1..65535; the down-counter is 16 bits.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `req`  in  `N_REQ`: request level, one bit per requester.
- `data`  in  8*`N_REQ`: flattened bytes; requester i owns `[8*i+8:8*i+1]`.
- `ack`  out  `N_REQ`: one-cycle pulse; the byte has been taken.
- `start`  out  1: to `sender.start`; active-low, one cycle wide.
- `message`  out  8 (`[8:1]`): to `sender.message`; holds its value until the next grant.
- `busy`  out  1: high while a frame is in flight.
- `grant`  out  `IDW`: index of the most recently granted requester.

## Operation
- State machine with three states:
  - IDLE: `busy`=0, `start`=1.
  - SEND: exactly one cycle.
  - WAIT: `FRAME_CLKS` cycles.
- IDLE -> SEND when any `req` bit is 1 at the clock edge. Registered updates at that edge:
  - `message` <= winner's byte; `grant` <= winner index.
  - `ack[winner]` <= 1; `start` <= 0; `busy` <= 1.
  - `last` <= winner.
- SEND -> WAIT unconditionally: `start` <= 1, `ack` <= 0, `cnt` <= `FRAME_CLKS`-1.
- WAIT: `cnt` decrements by 1 per cycle. When `cnt`==0: -> IDLE, `busy` <= 0.
- Round-robin search:
  - Starts at (`last`+1) mod `N_REQ` and scans upward, wrapping from `N_REQ`-1 to 0.
  - The first set `req` bit wins.
  - `last` resets to `N_REQ`-1, so requester 0 has highest priority after reset.
- `req` is sampled only in IDLE. Requests raised during SEND/WAIT wait for the next IDLE cycle; there is no queueing.
- Requester contract:
  - Hold `req` and `data` stable until `ack`.
  - A request dropped before grant is never served.
  - `req` still high on the cycle after `ack` counts as a new request.
- Simultaneous requests: exactly one `ack` bit is ever high in a cycle; all other requesters keep waiting.
- Reset mid-operation (`RST` in SEND or WAIT): next state IDLE, with all outputs at their reset values on the following cycle.
  - The sender's frame already in progress is not aborted.
  - The acked byte may be truncated on the line; recovering it is the requester's responsibility.
- Reset values: `start`=1, `ack`=0, `message`=8'h00, `busy`=0, `grant`=0, `cnt`=0, state IDLE, `last`=`N_REQ`-1.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Latency: `req` high at edge k gives `ack`/`start` low/`message` valid during cycle k+1 (the SEND cycle).
- `message` is stable on the same edge the sender samples `start`=0, and stays stable through the whole frame.
- `busy` is high for 1+`FRAME_CLKS` cycles per grant.
- Minimum IDLE dwell is 1 cycle, so back-to-back `start` pulses are spaced 2+`FRAME_CLKS` cycles apart. This is 52 cycles at the defaults.
- `cnt` never wraps: its load value is bounded by the `FRAME_CLKS` range check. `FRAME_CLKS`=1 gives a single WAIT cycle.

## Test plan
All scenarios use default parameters (`FRAME_CLKS`=50).
- **Single request.** `req`=4'b0010, byte 1 = 8'hB5 -> in the same cycle: `ack`=4'b0010 for 1 cycle, `start`=0 for 1 cycle, `message`=8'hB5, `grant`=1. Then `busy` high for exactly 51 cycles and `start` returns to 1. With the sender attached, TX shows the frame 0,1,0,1,0,1,1,0,1,1 at 5 cycles per bit.
- **All four requesting continuously.** Grants occur in order 0,1,2,3,0; consecutive `start` falling edges are 52 cycles apart; every `ack` is one cycle wide and only one bit is ever set.
- **Wrap-around.** After a grant to 3, `req`=4'b1001 -> next grant is 0. After that, with `req`=4'b1001 still held, the next grant is 3.
- **Late request.** `req[2]` rises in WAIT when `cnt`=20 -> no `ack` until IDLE; `ack[2]` appears exactly 1 cycle after `busy` falls.
- **Dropped request.** `req[1]` is pulsed during WAIT and removed before IDLE -> no `start` pulse and `busy` stays 0.
- **Reset mid-frame.** `RST`=1 for 1 cycle during WAIT with `cnt`=30 -> the next cycle shows `busy`=0, `start`=1, `ack`=0, `message`=8'h00. A subsequent `req`=4'b1111 is granted to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART sender among N_REQ byte producers.
// Grants one requester, drives its byte and a one-cycle active-low start, then times out the frame.
module uart_tx_arbiter #(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = 5,
   parameter int FRAME_BITS   = 10,
   parameter int GAP_CLKS     = 0,
   localparam int IDW         = $clog2(N_REQ)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ:1]     data,
   output logic [N_REQ-1:0]     ack,
   output logic                 start,
   output logic [8:1]           message,
   output logic                 busy,
   output logic [IDW-1:0]       grant
);

   localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS + GAP_CLKS;

   typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

   state_t           state, state_nxt;
   logic [15:0]      cnt;
   logic [IDW-1:0]   last;
   logic [IDW-1:0]   win;
   logic             found;

   // Scan upward from the requester after the last winner; first set bit wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         int idx;
         idx = (int'(last) + k) % N_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = IDW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = SEND;
         SEND:    state_nxt = WAIT;
         WAIT:    if (cnt == 16'd0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // All outputs are registered; they change only on the edges that move the FSM.
   always_ff @(posedge CLK) begin
      if (RST) begin
         start   <= 1'b1;
         ack     <= '0;
         message <= 8'h00;
         busy    <= 1'b0;
         grant   <= '0;
         cnt     <= 16'd0;
         last    <= IDW'(N_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  message  <= data[8*int'(win)+1 +: 8];
                  grant    <= win;
                  ack[win] <= 1'b1;
                  start    <= 1'b0;
                  busy     <= 1'b1;
                  last     <= win;
               end
            end
            SEND: begin
               start <= 1'b1;
               ack   <= '0;
               cnt   <= 16'(FRAME_CLKS - 1);
            end
            WAIT: begin
               if (cnt == 16'd0) busy <= 1'b0;
               else              cnt  <= cnt - 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed stimulus queues expected grants,
// a negedge monitor compares every start/ack event and every busy window length.
module tb_uart_tx_arbiter;

   localparam int N_REQ    = 4;
   localparam int BUSY_LEN = 51;

   typedef struct {
      int         id;
      logic [7:0] b;
      int         at;
   } exp_t;

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic [3:0]       req = '0;
   logic [32:1]      data;
   logic [3:0]       ack;
   logic             start;
   logic [8:1]       message;
   logic             busy;
   logic [1:0]       grant;

   logic [7:0]       byte_tab [4] = '{8'h3C, 8'hB5, 8'h5A, 8'hC3};
   exp_t             sb [$];
   int               checks   = 0;
   int               failures = 0;
   int               cyc      = 0;
   int               run      = 0;
   bit               run_abort = 1'b0;

   uart_tx_arbiter dut (
      .CLK     (CLK),
      .RST     (RST),
      .req     (req),
      .data    (data),
      .ack     (ack),
      .start   (start),
      .message (message),
      .busy    (busy),
      .grant   (grant)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   assign data = {byte_tab[3], byte_tab[2], byte_tab[1], byte_tab[0]};

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic expect_grant(input int id, input int at);
      exp_t e;
      e.id = id;
      e.b  = byte_tab[id];
      e.at = at;
      sb.push_back(e);
   endtask

   // Monitor: busy window length and every grant event against the scoreboard.
   always @(negedge CLK) begin
      if (busy === 1'b1) begin
         run++;
         if (RST) run_abort = 1'b1;
      end else if (run != 0) begin
         if (!run_abort) check("busy_len", run, BUSY_LEN);
         run       = 0;
         run_abort = 1'b0;
      end
      if (ack !== 4'b0000 && ack !== 4'bxxxx || start === 1'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_grant", {27'd0, ack, start}, 32'h1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("ack_cycle", cyc, e.at);
            check("ack_onehot", {28'd0, ack}, 32'(1) << e.id);
            check("start_low", {31'd0, start}, 32'h0);
            check("message", {24'd0, message}, {24'd0, e.b});
            check("grant", {30'd0, grant}, e.id);
            check("busy_send", {31'd0, busy}, 32'h1);
         end
      end
   end

   initial begin
      // Reset state
      wait_to(3);
      @(negedge CLK);
      check("rst_start", {31'd0, start}, 32'h1);
      check("rst_ack", {28'd0, ack}, 32'h0);
      check("rst_message", {24'd0, message}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      check("rst_grant", {30'd0, grant}, 32'h0);
      wait_to(4);
      RST = 1'b0;

      // Single request from requester 1
      wait_to(6);
      req = 4'b0010;
      expect_grant(1, 7);
      wait_to(7);
      req = 4'b0000;
      wait_to(60);
      @(negedge CLK);
      check("s1_idle_busy", {31'd0, busy}, 32'h0);
      check("s1_idle_start", {31'd0, start}, 32'h1);

      // Fresh reset, then all four requesting continuously
      RST = 1'b1;
      wait_to(62);
      RST = 1'b0;
      wait_to(64);
      req = 4'b1111;
      expect_grant(0, 65);
      expect_grant(1, 117);
      expect_grant(2, 169);
      expect_grant(3, 221);
      expect_grant(0, 273);
      wait_to(273);
      req = 4'b0000;

      // Wrap-around: grant 3, then 4'b1001 gives 0 then 3
      wait_to(330);
      req = 4'b1000;
      expect_grant(3, 331);
      wait_to(331);
      req = 4'b1001;
      expect_grant(0, 383);
      expect_grant(3, 435);
      wait_to(435);
      req = 4'b0000;

      // Late request: req[2] rises in WAIT with cnt=20
      wait_to(490);
      req = 4'b0001;
      expect_grant(0, 491);
      wait_to(491);
      req = 4'b0000;
      wait_to(521);
      req = 4'b0100;
      expect_grant(2, 543);
      wait_to(542);
      @(negedge CLK);
      check("late_busy_fell", {31'd0, busy}, 32'h0);
      wait_to(543);
      req = 4'b0000;

      // Dropped request: req[1] pulsed during WAIT only
      wait_to(600);
      req = 4'b0001;
      expect_grant(0, 601);
      wait_to(601);
      req = 4'b0000;
      wait_to(611);
      req = 4'b0010;
      wait_to(621);
      req = 4'b0000;
      wait_to(700);
      @(negedge CLK);
      check("drop_busy", {31'd0, busy}, 32'h0);
      check("drop_start", {31'd0, start}, 32'h1);

      // Reset mid-frame at cnt=30, then 4'b1111 goes to requester 0
      wait_to(710);
      req = 4'b0010;
      expect_grant(1, 711);
      wait_to(711);
      req = 4'b0000;
      wait_to(731);
      RST = 1'b1;
      wait_to(732);
      RST = 1'b0;
      @(negedge CLK);
      check("mid_rst_busy", {31'd0, busy}, 32'h0);
      check("mid_rst_start", {31'd0, start}, 32'h1);
      check("mid_rst_ack", {28'd0, ack}, 32'h0);
      check("mid_rst_message", {24'd0, message}, 32'h0);
      req = 4'b1111;
      expect_grant(0, 733);
      wait_to(733);
      req = 4'b0000;

      wait_to(800);
      check("sb_drained", sb.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
